// File: rtl/spi_slave.sv
// spi_slave: register-mapped SPI slave with tx/rx FIFOs and 2-flop synchronized SPI inputs.
// Define SPI_SLAVE_ERROR_FLAGS_EN to get sticky rxOverflow/txUnderrun status bits (clear by write-1 at address 2).
`timescale 1ns/1ps
module spi_slave #(
    parameter int DATAWIDTH   = 8,
    parameter int BUFFERDEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  address,
    input  logic [31:0] dataIn,
    output logic        readValid,
    output logic [31:0] dataOut,
    output logic        transmitIrq,
    output logic        receiveIrq,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss,
    output logic        miso,
    output logic        misoOe
);
    localparam int AW = (BUFFERDEPTH > 1) ? $clog2(BUFFERDEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(BUFFERDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [DATAWIDTH-1:0] shift_in(input logic [DATAWIDTH-1:0] sr,
                                                      input logic b, input logic lsb);
        logic [DATAWIDTH-1:0] r;
        if (lsb) begin
            r = sr >> 1;
            r[DATAWIDTH-1] = b;
        end else begin
            r = sr << 1;
            r[0] = b;
        end
        return r;
    endfunction

    function automatic logic out_bit(input logic [DATAWIDTH-1:0] sr, input logic lsb);
        return lsb ? sr[0] : sr[DATAWIDTH-1];
    endfunction

    function automatic logic [DATAWIDTH-1:0] advance(input logic [DATAWIDTH-1:0] sr, input logic lsb);
        return lsb ? (sr >> 1) : (sr << 1);
    endfunction

    logic sclk_m, sclk_s, sclk_d, mosi_m, mosi_s, ss_m, ss_s, ss_d;
    state_t state, state_next;
    logic [4:0] cfg;
    logic [2:0] cfg_act, cfg_use;
    logic cpol, cpha, lsb;
    logic rise, fall, lead, trail, sample_edge, shift_edge, ss_fall, last_bit;
    logic do_load, do_sample, do_shift, frame_done;
    logic [5:0] bit_cnt;
    logic [DATAWIDTH-1:0] tx_sr, rx_sr, rx_next, load_word;
    logic miso_bit;

    logic [DATAWIDTH-1:0] tx_mem [BUFFERDEPTH];
    logic [DATAWIDTH-1:0] rx_mem [BUFFERDEPTH];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    logic rx_overflow, tx_underrun, idle;
    logic [31:0] rdata;
    logic unused_din;

    assign unused_din = ^dataIn[31:5];

    // Input synchronizers; sclk_d/ss_d give one more stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_m <= 1'b0;
            sclk_s <= 1'b0;
            sclk_d <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
            ss_m   <= 1'b1;
            ss_s   <= 1'b1;
            ss_d   <= 1'b1;
        end else begin
            sclk_m <= sclk;
            sclk_s <= sclk_m;
            sclk_d <= sclk_s;
            mosi_m <= mosi;
            mosi_s <= mosi_m;
            ss_m   <= ss;
            ss_s   <= ss_m;
            ss_d   <= ss_s;
        end
    end

    // Frame-shape bits are frozen while shifting so mid-frame config writes wait for the next LOAD
    assign cfg_use = (state == SHIFT) ? cfg_act : cfg[2:0];
    assign cpol    = cfg_use[0];
    assign cpha    = cfg_use[1];
    assign lsb     = cfg_use[2];

    assign rise        = sclk_s & ~sclk_d;
    assign fall        = ~sclk_s & sclk_d;
    assign lead        = cpol ? fall : rise;
    assign trail       = cpol ? rise : fall;
    assign sample_edge = cpha ? trail : lead;
    assign shift_edge  = cpha ? lead : trail;
    assign ss_fall     = ~ss_s & ss_d;
    assign last_bit    = (bit_cnt == 6'(DATAWIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ss_fall) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (sample_edge && last_bit) state_next = LOAD;
            default: state_next = IDLE;
        endcase
        if (ss_s) state_next = IDLE;
    end

    // With cpha=0 the first bit is preloaded, so the trailing edge before any sample must not shift
    always_comb begin
        do_load    = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        frame_done = 1'b0;
        if (!ss_s) begin
            case (state)
                LOAD: do_load = 1'b1;
                SHIFT: begin
                    do_sample  = sample_edge;
                    do_shift   = shift_edge & (cpha | (bit_cnt != 6'd0));
                    frame_done = sample_edge & last_bit;
                end
                default: ;
            endcase
        end
    end

    assign load_word = tx_empty ? '0 : tx_mem[tx_rd];
    assign rx_next   = shift_in(rx_sr, mosi_s, lsb);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            miso_bit <= 1'b0;
            cfg_act  <= '0;
        end else begin
            cfg_act <= cfg_use;
            if (ss_s || state == IDLE) begin
                bit_cnt  <= '0;
                miso_bit <= 1'b0;
            end else begin
                if (do_load) begin
                    bit_cnt <= '0;
                    if (cpha) begin
                        tx_sr    <= load_word;
                        miso_bit <= 1'b0;
                    end else begin
                        tx_sr    <= advance(load_word, lsb);
                        miso_bit <= out_bit(load_word, lsb);
                    end
                end
                if (do_shift) begin
                    miso_bit <= out_bit(tx_sr, lsb);
                    tx_sr    <= advance(tx_sr, lsb);
                end
                if (do_sample) begin
                    rx_sr   <= rx_next;
                    bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
                end
            end
        end
    end

    assign tx_full  = (tx_cnt == CW'(BUFFERDEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(BUFFERDEPTH));
    assign rx_empty = (rx_cnt == '0);

    assign tx_push = write && (address == 2'd0) && !tx_full;
    assign tx_pop  = do_load && !tx_empty;
    assign rx_pop  = read && (address == 2'd1) && !rx_empty;
    assign rx_push = frame_done && (!rx_full || rx_pop);
    assign rx_drop = frame_done && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= dataIn[DATAWIDTH-1:0];
        if (rx_push) rx_mem[rx_wr] <= rx_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= ptr_inc(tx_wr);
            if (tx_pop)  tx_rd <= ptr_inc(tx_rd);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: ;
            endcase
            if (rx_push) rx_wr <= ptr_inc(rx_wr);
            if (rx_pop)  rx_rd <= ptr_inc(rx_rd);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg <= '0;
        end else if (write && address == 2'd3) begin
            cfg <= dataIn[4:0];
        end
    end

`ifdef SPI_SLAVE_ERROR_FLAGS_EN
    // A new error in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (write && address == 2'd2) begin
                if (dataIn[3]) rx_overflow <= 1'b0;
                if (dataIn[4]) tx_underrun <= 1'b0;
            end
            if (rx_drop)             rx_overflow <= 1'b1;
            if (do_load && tx_empty) tx_underrun <= 1'b1;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = rx_drop;
    assign rx_overflow  = 1'b0;
    assign tx_underrun  = 1'b0;
`endif

    assign idle = ss_s & tx_empty;

    always_comb begin
        rdata = '0;
        case (address)
            2'd1:    if (!rx_empty) rdata = 32'(rx_mem[rx_rd]);
            2'd2:    rdata = {27'd0, tx_underrun, rx_overflow, idle, !rx_empty, !tx_full};
            2'd3:    rdata = {27'd0, cfg};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readValid   <= 1'b0;
            dataOut     <= '0;
            transmitIrq <= 1'b0;
            receiveIrq  <= 1'b0;
            misoOe      <= 1'b0;
        end else begin
            readValid   <= read;
            dataOut     <= read ? rdata : 32'd0;
            transmitIrq <= cfg[3] & ~tx_full;
            receiveIrq  <= cfg[4] & ~rx_empty;
            misoOe      <= ~ss_s;
        end
    end

    assign miso = misoOe & miso_bit;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave acting as SPI master and bus host.
`timescale 1ns/1ps
module tb_spi_slave;
    localparam int W    = 8;
    localparam int HALF = 5;
`ifdef SPI_SLAVE_ERROR_FLAGS_EN
    localparam logic [31:0] ERR = 32'd1;
`else
    localparam logic [31:0] ERR = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset, read, write, sclk, mosi, ss;
    logic [1:0] address;
    logic [31:0] dataIn, dataOut;
    logic readValid, transmitIrq, receiveIrq, miso, misoOe;
    logic cpol_m = 1'b0, cpha_m = 1'b0, lsb_m = 1'b0;
    int checks = 0;
    int errors = 0;

    spi_slave #(.DATAWIDTH(W), .BUFFERDEPTH(16)) dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .dataIn(dataIn), .readValid(readValid), .dataOut(dataOut),
        .transmitIrq(transmitIrq), .receiveIrq(receiveIrq),
        .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso), .misoOe(misoOe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; address = a; dataIn = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        read = 1'b1; address = a;
        @(negedge clk);
        read = 1'b0;
        check("readValid", 32'(readValid), 32'd1);
        d = dataOut;
    endtask

    task automatic set_mode(input logic [31:0] c);
        bus_write(2'd3, c);
        cpol_m = c[0]; cpha_m = c[1]; lsb_m = c[2];
    endtask

    task automatic ss_low();
        sclk = cpol_m;
        wait_clk(4);
        ss = 1'b0;
        wait_clk(6);
        check("misoOe_on", 32'(misoOe), 32'd1);
    endtask

    task automatic ss_high();
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(6);
        check("misoOe_off", 32'(misoOe), 32'd0);
        check("miso_off", 32'(miso), 32'd0);
    endtask

    task automatic frame(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        int idx;
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb_m ? i : W - 1 - i;
            if (!cpha_m) begin
                mosi = tx[idx];
                wait_clk(HALF);
                sclk = ~sclk;
                rx[idx] = miso;
                wait_clk(HALF);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                mosi = tx[idx];
                wait_clk(HALF);
                sclk = ~sclk;
                rx[idx] = miso;
                wait_clk(HALF);
            end
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        ss_low();
        frame(tx, W, rx);
        ss_high();
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0] r;
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 2'd0; dataIn = '0;
        sclk = 1'b0; mosi = 1'b0; ss = 1'b1;
        wait_clk(3);
        check("rst_readValid", 32'(readValid), 32'd0);
        check("rst_dataOut", dataOut, 32'd0);
        check("rst_misoOe", 32'(misoOe), 32'd0);
        reset = 1'b0;
        wait_clk(3);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_txirq", 32'(transmitIrq), 32'd0);
        check("rst_rxirq", 32'(receiveIrq), 32'd0);
        bus_read(2'd2, d); check("rst_status", d, 32'h05);
        bus_read(2'd3, d); check("rst_config", d, 32'h00);

        // Mode 0, MSB first
        set_mode(32'h00);
        bus_write(2'd0, 32'hA5);
        spi_xfer(8'h3C, r);
        check("m0_miso_word", 32'(r), 32'hA5);
        bus_read(2'd1, d); check("m0_rx", d, 32'h3C);
        @(negedge clk);
        check("rv_drop", 32'(readValid), 32'd0);
        check("dout_zero", dataOut, 32'd0);

        // All four modes, LSB first
        for (int m = 0; m < 4; m++) begin
            set_mode(32'h4 | 32'(m));
            bus_write(2'd0, 32'h80);
            spi_xfer(8'h01, r);
            check($sformatf("mode%0d_miso", m), 32'(r), 32'h80);
            bus_read(2'd1, d); check($sformatf("mode%0d_rx", m), d, 32'h01);
        end

        // Underrun with empty tx
        set_mode(32'h00);
        spi_xfer(8'h55, r);
        check("under_miso", 32'(r), 32'h00);
        bus_read(2'd2, d); check("under_status", d, 32'h07 | (ERR << 4));
        bus_write(2'd2, 32'h10);
        bus_read(2'd2, d); check("under_clr", d, 32'h07);
        bus_read(2'd1, d); check("under_rx", d, 32'h55);

        // Partial frame is discarded
        ss_low();
        frame(8'hFF, 5, r);
        ss_high();
        bus_read(2'd2, d); check("partial_rxvalid", 32'(d[1]), 32'd0);
        spi_xfer(8'h12, r);
        bus_read(2'd1, d); check("after_partial_rx", d, 32'h12);
        bus_write(2'd2, 32'h18);

        // Fill tx, drop the extra push, then back-to-back frames with ss held low
        for (int i = 0; i < 16; i++) bus_write(2'd0, 32'h40 + 32'(i));
        bus_read(2'd2, d); check("txfull_status", d, 32'h00);
        bus_write(2'd0, 32'h99);
        ss_low();
        for (int i = 0; i < 16; i++) begin
            frame(8'h20 + 8'(i), W, r);
            check($sformatf("burst_miso%0d", i), 32'(r), 32'h40 + 32'(i));
            bus_read(2'd1, d); check($sformatf("burst_rx%0d", i), d, 32'h20 + 32'(i));
        end
        frame(8'h30, W, r);
        check("burst_drop_miso", 32'(r), 32'h00);
        ss_high();
        bus_read(2'd2, d); check("burst_status", d, 32'h07 | (ERR << 4));
        bus_read(2'd1, d); check("burst_last_rx", d, 32'h30);
        bus_write(2'd2, 32'h18);

        // rx overflow: 17 frames into a 16-deep FIFO
        for (int i = 1; i <= 17; i++) spi_xfer(8'(i), r);
        bus_read(2'd2, d); check("ovf_status", d, 32'h07 | (ERR << 3) | (ERR << 4));
        for (int i = 1; i <= 16; i++) begin
            bus_read(2'd1, d); check($sformatf("ovf_rx%0d", i), d, 32'(i));
        end
        bus_read(2'd1, d); check("empty_rx", d, 32'h00);
        bus_read(2'd2, d); check("ovf_status_end", d, 32'h05 | (ERR << 3) | (ERR << 4));
        bus_write(2'd2, 32'h18);

        // Interrupts
        set_mode(32'h18);
        wait_clk(3);
        check("irq_tx", 32'(transmitIrq), 32'd1);
        check("irq_rx_idle", 32'(receiveIrq), 32'd0);
        spi_xfer(8'h77, r);
        wait_clk(2);
        check("irq_rx", 32'(receiveIrq), 32'd1);
        bus_read(2'd3, d); check("cfg_readback", d, 32'h18);
        bus_read(2'd1, d); check("irq_rx_word", d, 32'h77);
        wait_clk(3);
        check("irq_rx_clear", 32'(receiveIrq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8: frame width in bits, 1..32.
REQ-002 SHALL have parameter BUFFERDEPTH, default 16: entries in each of the tx and rx FIFOs, power of two.
REQ-003 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have ports read / write  input  1 each: one-cycle bus strobes, never asserted together.
REQ-006 SHALL have ports address  input  2 and dataIn  input  32: register select and write data.
REQ-007 SHALL have ports readValid  output  1 and dataOut  output  32: read response.
REQ-008 SHALL have ports transmitIrq / receiveIrq  output  1 each: level interrupts.
REQ-009 SHALL have ports sclk, mosi, ss  input  1 each: SPI bus from the master; ss active-low.
REQ-010 SHALL have ports miso  output  1 and misoOe  output  1: slave data and its output enable.

Function
REQ-011 SHALL pass sclk, mosi, ss through 2-flop synchronizers; sclk period SHALL be >= 8 clk periods.
REQ-012 SHALL map addresses: 0 write = push tx FIFO; 1 read = pop rx FIFO; 2 = status; 3 = config.
REQ-013 SHALL return status as bit0 txReady (tx not full), bit1 rxValid (rx not empty), bit2 idle (ss high and tx empty), bit3 rxOverflow, bit4 txUnderrun, other bits 0.
REQ-014 SHALL hold config as bit0 cpol, bit1 cpha, bit2 lsbFirst, bit3 txIrqEn, bit4 rxIrqEn; readable back.
REQ-015 SHALL assert readValid exactly one cycle after a read strobe, for one cycle, with dataOut valid; dataOut 0 otherwise.
REQ-016 SHALL return 0 and leave pointers unchanged for address-1 reads while rx is empty; tx pushes while full are dropped.
REQ-017 SHALL use states IDLE, LOAD, SHIFT: IDLE->LOAD on synchronized ss falling; LOAD->SHIFT after one cycle; SHIFT->LOAD after DATAWIDTH sample edges with ss low; any state->IDLE on ss high.
REQ-018 In LOAD SHALL pop tx head into the shift register, or load 0 and set txUnderrun if tx is empty.
REQ-019 SHALL sample mosi on the leading sclk edge when cpha=0, trailing when cpha=1; leading = rising when cpol=0, falling when cpol=1.
REQ-020 SHALL update miso on the opposite edge; when cpha=0 the first bit SHALL be on miso by the end of LOAD.
REQ-021 SHALL shift MSB first when lsbFirst=0, LSB first when lsbFirst=1, for both directions.
REQ-022 SHALL push the received word to rx after the DATAWIDTH-th sample; if rx is full the word is dropped and rxOverflow set.
REQ-023 SHALL discard a partial frame on ss rising mid-frame: no rx push, bit counter cleared, popped tx word lost.
REQ-024 SHALL drive misoOe=1 only while ss is low (synchronized) and miso=0 whenever misoOe=0.
REQ-025 SHALL drive transmitIrq = txIrqEn & txReady and receiveIrq = rxIrqEn & rxValid, registered.
REQ-026 SHALL, when a config write occurs outside IDLE, apply it from the next LOAD only.
REQ-027 SHALL, on simultaneous rx pop and push, perform both with occupancy unchanged.

Reset
REQ-028 SHALL on reset set state IDLE, FIFOs empty, config 0, flags 0, shift register and bit counter 0.
REQ-029 SHALL hold readValid, dataOut, miso, misoOe, transmitIrq, receiveIrq at 0 during and after reset until changed by function.
REQ-030 SHALL on reset mid-frame abandon the frame; the master-side frame is not recovered.

Configuration
REQ-031 With macro SPI_SLAVE_ERROR_FLAGS_EN defined, rxOverflow and txUnderrun SHALL be sticky and cleared by writing 1 to the bit at address 2.
REQ-032 Without SPI_SLAVE_ERROR_FLAGS_EN, status bits 3 and 4 SHALL read 0, address-2 writes SHALL be ignored, and data-path behaviour SHALL be identical.

Verification
REQ-033 Mode 0, MSB first: push 0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; address-1 read returns 0x3C.
REQ-034 All four cpol/cpha modes, lsbFirst=1: master sends 0x01 -> rx reads 0x01; pushed 0x80 arrives at master as 0x80.
REQ-035 Tx empty at ss fall -> miso all 0; status bit4=1; write 0x10 to address 2 -> bit4=0.
REQ-036 Master sends 17 words with BUFFERDEPTH=16, no pops -> 16 words readable in order, status bit3=1.
REQ-037 ss raised after 5 bits of 0xFF -> no rx push, rxValid stays 0; next full frame 0x12 read back as 0x12.
REQ-038 Config 0x18 with tx empty and rx empty -> transmitIrq=1, receiveIrq=0; after one received frame receiveIrq=1.
